// File: rtl/uart_byte_feeder.sv
// uart_byte_feeder
// Receives 8N1 UART bytes, buffers them in a small circular FIFO and presents
// the head byte to the downstream bit-rate stage. When nothing is buffered,
// the output carries IDLE_BYTE so the modulator keeps a steady tone.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   uart_rx    asynchronous serial input (idles high)
//   byte_done  one-cycle pulse: downstream has consumed the head byte
//   data       head byte when data_valid, else IDLE_BYTE
//   data_valid FIFO non-empty
//   fifo_full  FIFO holds DEPTH entries
//   overflow   one-cycle pulse: received byte dropped, FIFO was full
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
module uart_byte_feeder #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         BAUD      = 9600,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       byte_done,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       fifo_full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TMR_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Two-flop synchronizer; resets to the idle line level.
  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Receive FSM
  logic [1:0]       state_reg, state_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             push_req;
  logic             frame_err_next;

  always_comb begin
    state_next     = state_reg;
    tmr_next       = tmr_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    push_req       = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rx_sync_reg) begin
          tmr_next   = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        // Half-bit wait lands later samples near the middle of each bit.
        if (tmr_reg == TMR_W'(HALF_BIT - 1)) begin
          tmr_next     = '0;
          bit_cnt_next = 3'd0;
          state_next   = rx_sync_reg ? S_IDLE : S_DATA;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (tmr_reg == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_next     = '0;
          shift_next   = {rx_sync_reg, shift_reg[7:1]};  // LSB arrives first
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = S_STOP;
          end
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (tmr_reg == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_next   = '0;
          state_next = S_IDLE;
          if (rx_sync_reg) begin
            push_req = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      tmr_reg     <= '0;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      state_reg   <= state_next;
      tmr_reg     <= tmr_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  // FIFO. The push uses shift_reg directly: the stop bit is sampled after
  // the last data bit was shifted in, so the holding register is complete.
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             is_full, is_empty;
  logic             pop, push_ok, drop;
  logic             overflow_reg, frame_err_reg;

  assign is_full  = (count_reg == CNT_W'(DEPTH));
  assign is_empty = (count_reg == '0);
  assign pop      = byte_done && !is_empty;
  // A simultaneous pop frees a slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!is_full || pop);
  assign drop     = push_req && !push_ok;

  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      count_reg     <= count_next;
      overflow_reg  <= drop;
      frame_err_reg <= frame_err_next;
    end
  end

  // Storage needs no reset: stale entries are masked by count_reg.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  assign data       = is_empty ? IDLE_BYTE : mem[rd_ptr_reg];
  assign data_valid = !is_empty;
  assign fifo_full  = is_full;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;

endmodule
